// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : Instruction fetch front end. Owns the PC, issues word requests,
//            buffers responses in an in-order queue and hands them to decode.
//            Optional misaligned-redirect check: FETCH_ALIGN_CHK_EN.
// Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        fetch_err
);

    localparam int                 c_CNT_W     = $clog2(DEPTH) + 1;
    localparam int                 c_CNT_W1    = c_CNT_W + 1;
    localparam int                 c_PTR_W     = $clog2(DEPTH);
    localparam logic [c_CNT_W-1:0] c_DEPTH     = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W:0]   c_DEPTH_EXT = c_CNT_W1'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

    logic [31:0]        r_pc;
    logic [31:0]        r_rsp_pc;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] r_inflight;
    logic [c_CNT_W-1:0] r_drop;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [31:0]        r_q_instr [DEPTH];
    logic [31:0]        r_q_pc    [DEPTH];

    logic [31:0]        w_redirect_pc;
    logic [c_CNT_W:0]   w_pending;
    logic               w_halt;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_rsp_drop;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHK_EN
    logic r_fetch_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_err <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            r_fetch_err <= 1'b1;
        end
    end

    assign fetch_err = r_fetch_err;
    assign w_halt    = r_fetch_err;
`else
    logic w_unused_pc_lsb;

    assign w_unused_pc_lsb = |redirect_pc[1:0];
    assign fetch_err       = 1'b0;
    assign w_halt          = 1'b0;
`endif

    // Credit: queued words plus live (non-discarded) in-flight requests.
    assign w_pending = {1'b0, r_count} + {1'b0, r_inflight} - {1'b0, r_drop};

    assign imem_req_valid = !redirect_valid && !w_halt
                          && (w_pending < c_DEPTH_EXT) && (r_inflight < c_DEPTH);
    assign imem_req_addr  = r_pc;

    assign instr_valid = (r_count != '0);
    assign instr       = r_q_instr[r_rd_ptr];
    assign instr_pc    = r_q_pc[r_rd_ptr];

    assign w_accept   = imem_req_valid && imem_req_ready;
    assign w_pop      = instr_valid && instr_ready;
    assign w_rsp_drop = imem_rsp_valid && (r_drop != '0);
    assign w_push     = imem_rsp_valid && (r_drop == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
            end
        end else if (redirect_valid) begin
            // Every outstanding request is stale; one answered now is already gone.
            r_pc       <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_inflight <= r_inflight - c_CNT_W'(imem_rsp_valid);
            r_drop     <= r_inflight - c_CNT_W'(imem_rsp_valid);
        end else begin
            if (w_accept) begin
                r_pc <= r_pc + 32'd4;
            end
            r_inflight <= r_inflight + c_CNT_W'(w_accept) - c_CNT_W'(imem_rsp_valid);
            if (w_rsp_drop) begin
                r_drop <= r_drop - c_CNT_ONE;
            end
            if (w_push) begin
                r_q_instr[r_wr_ptr] <= imem_rsp_data;
                r_q_pc[r_wr_ptr]    <= r_rsp_pc;
                r_wr_ptr            <= r_wr_ptr + c_PTR_ONE;
                r_rsp_pc            <= r_rsp_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
        end
    end

endmodule
`default_nettype wire
